// File: rtl/red_pitaya_iq_demod_avg_block.sv
// IQ demodulator with integrate-and-dump decimation: signal_i*sin -> I, signal_i*cos -> Q,
// summed over 2^d samples, then emitted as one rounded, saturated pair per window.
// Latency: last sample of a window registered at edge k -> valid_o high after edge k+3.
// Backpressure: none. A new sample is accepted on every clock and valid_o is a one-cycle strobe.
//
// Ports:
//   clk_i, rstn_i     clock, asynchronous active-low reset
//   signal_i          signed input sample (INBITS)
//   sin, cos          signed references for the I and Q paths (SINBITS)
//   dec_log2_i        log2 window length, clamped to MAXLOG and latched at each window start
//   sync_i            restarts the window; the sample on the same edge is the window's first
//   i_o, q_o          averaged I/Q (OUTBITS), held between dumps
//   valid_o           one-cycle pulse when i_o/q_o update
module red_pitaya_iq_demod_avg_block #(
    parameter int INBITS  = 14,
    parameter int SINBITS = 14,
    parameter int OUTBITS = 18,
    parameter int MAXLOG  = 10,
    parameter int LOGW    = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic signed [INBITS-1:0]  signal_i,
    input  logic signed [SINBITS-1:0] sin,
    input  logic signed [SINBITS-1:0] cos,
    input  logic        [LOGW-1:0]    dec_log2_i,
    input  logic                      sync_i,
    output logic signed [OUTBITS-1:0] i_o,
    output logic signed [OUTBITS-1:0] q_o,
    output logic                      valid_o
);

    localparam int PW    = SINBITS + INBITS;
    localparam int ACCW  = PW + MAXLOG;
    localparam int CW    = MAXLOG + 1;
    localparam int SBASE = PW - 1 - OUTBITS;

    localparam logic signed [ACCW:0] OMAX = {{(ACCW + 2 - OUTBITS){1'b0}}, {(OUTBITS - 1){1'b1}}};
    localparam logic signed [ACCW:0] OMIN = {{(ACCW + 2 - OUTBITS){1'b1}}, {(OUTBITS - 1){1'b0}}};

    // Stage 1: input registers. v1_q/v2_q mark real samples so the cleared
    // pipeline contents after reset are never counted into a window.
    logic signed [INBITS-1:0]  sig_q;
    logic signed [SINBITS-1:0] sin_q, cos_q;
    logic                      sync1_q, v1_q;

    // Stage 2: products
    logic signed [PW-1:0]      prod_i_q, prod_q_q, prod_i_d, prod_q_d;
    logic                      sync2_q, v2_q;

    // Stage 3: accumulators and window control
    logic signed [ACCW-1:0]    acc_i_q, acc_q_q, acc_i_d, acc_q_d;
    logic        [CW-1:0]      cnt_q, cnt_d;
    logic        [LOGW-1:0]    d_lat_q, d_lat_d;
    logic                      dump_q, dump_d;

    // Stage 4: outputs
    logic signed [OUTBITS-1:0] i_q, q_q, i_d, q_d;
    logic                      valid_q;

    // Window-control intermediates
    logic        [LOGW-1:0]    dec_clamp, d_eff;
    logic                      start;
    logic        [CW-1:0]      idx, mask;
    logic        [7:0]         s_amt;

    // Round half up at bit s-1, arithmetic shift by s, clamp to OUTBITS.
    function automatic logic signed [OUTBITS-1:0] round_sat(input logic signed [ACCW-1:0] a,
                                                            input logic [7:0] s);
        logic signed [ACCW:0] ext;
        logic signed [ACCW:0] half;
        logic signed [ACCW:0] shf;
        ext  = {a[ACCW-1], a};
        half = '0;
        if (s != 8'd0) begin
            half = (ACCW + 1)'(1) << (s - 8'd1);
        end
        shf = (ext + half) >>> s;
        if (shf > OMAX) begin
            round_sat = OMAX[OUTBITS-1:0];
        end else if (shf < OMIN) begin
            round_sat = OMIN[OUTBITS-1:0];
        end else begin
            round_sat = shf[OUTBITS-1:0];
        end
    endfunction

    always_comb begin
        logic signed [PW-1:0] sig_x, sin_x, cos_x;
        sig_x    = {{SINBITS{sig_q[INBITS-1]}}, sig_q};
        sin_x    = {{INBITS{sin_q[SINBITS-1]}}, sin_q};
        cos_x    = {{INBITS{cos_q[SINBITS-1]}}, cos_q};
        prod_i_d = sig_x * sin_x;
        prod_q_d = sig_x * cos_x;
    end

    always_comb begin
        dec_clamp = (dec_log2_i > LOGW'(MAXLOG)) ? LOGW'(MAXLOG) : dec_log2_i;
        start     = sync2_q || (cnt_q == '0);
        d_eff     = start ? dec_clamp : d_lat_q;
        idx       = start ? '0 : cnt_q;
        mask      = (CW'(1) << d_eff) - CW'(1);

        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_d   = cnt_q;
        d_lat_d = d_lat_q;
        dump_d  = 1'b0;
        if (v2_q) begin
            if (start) begin
                acc_i_d = {{MAXLOG{prod_i_q[PW-1]}}, prod_i_q};
                acc_q_d = {{MAXLOG{prod_q_q[PW-1]}}, prod_q_q};
            end else begin
                acc_i_d = acc_i_q + {{MAXLOG{prod_i_q[PW-1]}}, prod_i_q};
                acc_q_d = acc_q_q + {{MAXLOG{prod_q_q[PW-1]}}, prod_q_q};
            end
            d_lat_d = d_eff;
            dump_d  = (idx == mask);
            cnt_d   = (idx == mask) ? '0 : idx + CW'(1);
        end
    end

    // d_lat_q here still belongs to the window being dumped; a window starting
    // on this same edge only updates it for the next dump.
    always_comb begin
        s_amt = 8'(d_lat_q) + 8'(SBASE);
        i_d   = i_q;
        q_d   = q_q;
        if (dump_q) begin
            i_d = round_sat(acc_i_q, s_amt);
            q_d = round_sat(acc_q_q, s_amt);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sig_q    <= '0;
            sin_q    <= '0;
            cos_q    <= '0;
            sync1_q  <= 1'b0;
            v1_q     <= 1'b0;
            prod_i_q <= '0;
            prod_q_q <= '0;
            sync2_q  <= 1'b0;
            v2_q     <= 1'b0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            cnt_q    <= '0;
            d_lat_q  <= '0;
            dump_q   <= 1'b0;
            i_q      <= '0;
            q_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            sig_q    <= signal_i;
            sin_q    <= sin;
            cos_q    <= cos;
            sync1_q  <= sync_i;
            v1_q     <= 1'b1;
            prod_i_q <= prod_i_d;
            prod_q_q <= prod_q_d;
            sync2_q  <= sync1_q;
            v2_q     <= v1_q;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            cnt_q    <= cnt_d;
            d_lat_q  <= d_lat_d;
            dump_q   <= dump_d;
            i_q      <= i_d;
            q_q      <= q_d;
            valid_q  <= dump_q;
        end
    end

    assign i_o     = i_q;
    assign q_o     = q_q;
    assign valid_o = valid_q;

endmodule
